// File: rtl/lv_owt_txn_ctrl.sv
// lv_owt_txn_ctrl: one-wire transaction controller.
// A received frame is decoded into a register write, a register read or an
// ADC read. Reads are answered with a response frame after a bus-turnaround
// gap. The response is abandoned if the transmitter never reports it as sent.
// Optional feature macro: LV_OWT_ERR_CNT_EN adds the saturating o_err_cnt
// error counter. The default build leaves the macro undefined.
module lv_owt_txn_ctrl #(
  parameter int               CMD_W    = 8,
  parameter int               DATA_W   = 16,
  parameter logic [CMD_W-2:0] ADC_ADDR = 7'h1f,
  parameter int               GAP_CYC  = 16,
  parameter int               TO_CYC   = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_ack,
  input  logic              i_rx_status,
  input  logic [CMD_W-1:0]  i_rx_cmd,
  input  logic [DATA_W-1:0] i_rx_data,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  output logic [CMD_W-2:0]  o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  input  logic [7:0]        i_reg_rdata,
  input  logic [DATA_W-1:0] i_adc_data,
  output logic              o_tx_req,
  output logic [CMD_W-1:0]  o_tx_cmd,
  output logic [DATA_W-1:0] o_tx_data,
  input  logic              i_tx_done,
  output logic              o_busy
`ifdef LV_OWT_ERR_CNT_EN
  ,
  output logic [7:0]        o_err_cnt
`endif
);

  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam int TO_W  = $clog2(TO_CYC) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_REG_WR = 3'd2;
  localparam logic [2:0] S_REG_RD = 3'd3;
  localparam logic [2:0] S_RD_CAP = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_TX     = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              gap_last;
  logic              to_expire;

  // Only the low byte of the frame data is register data.
  logic unused_rx_data;
  assign unused_rx_data = ^i_rx_data[DATA_W-1:8];

  assign gap_last  = (gap_cnt_q == GAP_W'(GAP_CYC - 1));
  assign to_expire = (state_q == S_TX) && (to_cnt_q == TO_W'(TO_CYC - 1));

  // Next-state and payload latch decode.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (i_rx_ack && !i_rx_status) begin
          cmd_d   = i_rx_cmd;
          wdata_d = i_rx_data[7:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cmd_q[CMD_W-1]) begin
          state_d = S_REG_WR;
        end else if (cmd_q[CMD_W-2:0] == ADC_ADDR) begin
          // ADC sample is frozen here so later sample changes cannot leak
          // into a response already in flight.
          resp_d  = i_adc_data;
          state_d = S_GAP;
        end else begin
          state_d = S_REG_RD;
        end
      end
      S_REG_WR: state_d = S_IDLE;
      S_REG_RD: state_d = S_RD_CAP;
      S_RD_CAP: begin
        resp_d  = DATA_W'(i_reg_rdata);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_last) state_d = S_TX;
      end
      S_TX: begin
        // A done pulse in the expiry cycle still completes the response.
        if (i_tx_done)      state_d = S_DONE;
        else if (to_expire) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gap and timeout counters restart on every state entry.
  always_comb begin
    gap_cnt_d = '0;
    to_cnt_d  = '0;
    if (state_q == S_GAP && state_d == S_GAP) gap_cnt_d = gap_cnt_q + GAP_W'(1);
    if (state_q == S_TX  && state_d == S_TX)  to_cnt_d  = to_cnt_q + TO_W'(1);
  end

  // State, payload and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      wdata_q   <= '0;
      resp_q    <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

`ifdef LV_OWT_ERR_CNT_EN
  logic       ev_rx;
  logic       ev_to;
  logic [8:0] err_sum;
  logic [7:0] err_q, err_d;

  // A bad-status frame in IDLE and any frame outside IDLE are the same
  // event class; they can coincide with a timeout in one cycle.
  assign ev_rx   = i_rx_ack && ((state_q != S_IDLE) || i_rx_status);
  assign ev_to   = to_expire && !i_tx_done;
  assign err_sum = {1'b0, err_q} + 9'(ev_rx) + 9'(ev_to);
  assign err_d   = err_sum[8] ? 8'hff : err_sum[7:0];

  // Saturating error counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign o_err_cnt = err_q;
`endif

  // Strobes and request decode straight from state, so reset drops them
  // without waiting for a clock.
  assign o_reg_wr    = (state_q == S_REG_WR);
  assign o_reg_rd    = (state_q == S_REG_RD);
  assign o_tx_req    = (state_q == S_TX);
  assign o_busy      = (state_q != S_IDLE);
  assign o_reg_addr  = cmd_q[CMD_W-2:0];
  assign o_reg_wdata = wdata_q;
  assign o_tx_cmd    = cmd_q;
  assign o_tx_data   = resp_q;

endmodule
